// File: rtl/button_sequencer.sv
// ---------------------------------------------------------------------------
// button_sequencer
//   Transmit side of the button path. Plays a stored key code onto a 4-bit
//   one-hot button bus. Each key gets a press of HOLD_CYCLES cycles and then
//   GAP_CYCLES cycles with all buttons released. The timing is long enough
//   for a downstream debouncer + edge detector to see exactly one pulse per
//   key.
//
// Ports
//   clk        in   1            system clock, rising edge
//   rstn       in   1            asynchronous active-low reset
//   start      in   1            request playback (sampled only while idle)
//   abort      in   1            synchronous cancel of playback in progress
//   code       in   2*CODE_LEN   key indices, key k = code[2k+1:2k], key 0 first
//   button     out  4            one-hot pressed key, 4'b0000 when released
//   busy       out  1            high while a sequence is playing
//   done       out  1            one-cycle pulse on normal completion
//   dbg_state  out  2            current FSM state (IDLE/PRESS/RELEASE)
//
// Handshake: start is a level request, not valid/ready. It is honoured in
// any cycle where the FSM is IDLE and abort is low (including the done
// cycle); while busy it is ignored and never queued.
// ---------------------------------------------------------------------------
module button_sequencer #(
    parameter int CODE_LEN    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2*CODE_LEN-1:0] code,
    output logic [3:0]            button,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(CODE_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*CODE_LEN-1:0] code_q, code_d;
    logic [3:0]            button_q, button_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      idx_inc;

    // Key lookup by loop so an index past the last key can never produce an
    // out-of-range part-select; such an index simply returns key 0.
    function automatic logic [1:0] key_at(input logic [2*CODE_LEN-1:0] c,
                                          input logic [IDX_W-1:0]      i);
        logic [1:0] k;
        k = c[1:0];
        for (int n = 0; n < CODE_LEN; n++) begin
            if (IDX_W'(n) == i) k = c[2*n +: 2];
        end
        return k;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    assign idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        button_d = button_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                button_d = 4'b0000;
                busy_d   = 1'b0;
                // abort beats start when both arrive in the same idle cycle
                if (start && !abort) begin
                    code_d   = code;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = PRESS;
                    button_d = onehot(code[1:0]);
                    busy_d   = 1'b1;
                end
            end

            PRESS: begin
                if (abort) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    idx_d    = '0;
                    button_d = 4'b0000;
                    busy_d   = 1'b0;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d  = RELEASE;
                    cnt_d    = '0;
                    button_d = 4'b0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (abort) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    idx_d    = '0;
                    button_d = 4'b0000;
                    busy_d   = 1'b0;
                end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = PRESS;
                        idx_d    = idx_inc;
                        button_d = onehot(key_at(code_q, idx_inc));
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                idx_d    = '0;
                cnt_d    = '0;
                button_d = 4'b0000;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            button_q <= 4'b0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            button_q <= button_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign button    = button_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_button_sequencer.sv
// ---------------------------------------------------------------------------
// tb_button_sequencer
//   Self-checking bench for button_sequencer with CODE_LEN=4, HOLD=4, GAP=4.
//   Each cycle is described as {done, busy, button[3:0]}. Drivers push the
//   per-cycle words they expect when they drive start; a negedge monitor pops
//   one word per cycle (an empty queue means "idle": all zero).
// ---------------------------------------------------------------------------
module tb_button_sequencer;

    localparam int LEN  = 4;
    localparam int HOLD = 4;
    localparam int GAP  = 4;

    logic           clk;
    logic           rstn;
    logic           start;
    logic           abort;
    logic [2*LEN-1:0] code;
    logic [3:0]     button;
    logic           busy;
    logic           done;
    logic [1:0]     dbg_state;

    logic [5:0] exp_q[$];
    int         total;
    int         bad;
    logic       mon_en;

    button_sequencer #(
        .CODE_LEN   (LEN),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .abort    (abort),
        .code     (code),
        .button   (button),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    // Pushes the expected words for cycles 1.. of a run started in cycle 0.
    // abort_at > 0: abort is driven in that cycle, so only cycles
    // 1..abort_at are pushed and the run is idle afterwards (no done).
    task automatic push_run(input logic [2*LEN-1:0] c, input int abort_at);
        logic [5:0] tmp[$];
        logic [1:0] k;
        for (int n = 0; n < LEN; n++) begin
            k = c[2*n +: 2];
            for (int h = 0; h < HOLD; h++) tmp.push_back({2'b01, 4'b0001 << k});
            for (int g = 0; g < GAP; g++)  tmp.push_back(6'b01_0000);
        end
        tmp.push_back(6'b10_0000);
        if (abort_at > 0) begin
            for (int i = 0; i < abort_at; i++) exp_q.push_back(tmp[i]);
        end else begin
            foreach (tmp[i]) exp_q.push_back(tmp[i]);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [5:0] e;
        if (mon_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'b00_0000;
            check("cycle", {done, busy, button}, e);
            check("onehot", 6'($countones(button) <= 1), 6'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            next_cycle();
            n++;
        end
        check("drain", 6'(exp_q.size()), 6'd0);
        repeat (3) next_cycle();
    endtask

    // One-cycle start pulse in cycle 0, optional abort in cycle abort_at.
    task automatic run_code(input logic [2*LEN-1:0] c, input int abort_at);
        next_cycle();
        code  = c;
        start = 1'b1;
        exp_q.push_back(6'b00_0000);   // cycle 0 itself is still idle
        push_run(c, abort_at);
        next_cycle();
        start = 1'b0;
        if (abort_at > 0) begin
            repeat (abort_at - 1) next_cycle();
            abort = 1'b1;
            next_cycle();
            abort = 1'b0;
        end
        wait_drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        rstn   = 1'b0;
        start  = 1'b1;
        abort  = 1'b0;
        code   = 8'b11_10_01_00;

        // Reset held with start high: everything stays at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_out", {done, busy, button}, 6'b00_0000);
        end
        @(negedge clk);
        start = 1'b0;
        rstn  = 1'b1;
        mon_en = 1'b1;
        repeat (3) next_cycle();

        // Basic playback, done in cycle 33.
        run_code(8'b11_10_01_00, 0);

        // Code change and start pulse in cycle 10 are ignored.
        next_cycle();
        code  = 8'b11_10_01_00;
        start = 1'b1;
        exp_q.push_back(6'b00_0000);
        push_run(8'b11_10_01_00, 0);
        next_cycle();
        start = 1'b0;
        repeat (9) next_cycle();
        code  = 8'b00_01_10_11;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_drain();

        // Abort in second key's press, then a full replay from key 0.
        run_code(8'b01_11_10_00, 10);
        run_code(8'b01_11_10_00, 0);

        // Abort on the very first busy cycle and in the last gap cycle.
        run_code(8'b10_10_11_01, 1);
        run_code(8'b00_11_01_10, 32);

        // Abort alone in IDLE: no effect. Abort with start: start dropped.
        next_cycle();
        abort = 1'b1;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        repeat (4) next_cycle();

        // Start held high: back-to-back runs, done at 33 and 66.
        next_cycle();
        code  = 8'b00_01_11_10;
        start = 1'b1;
        exp_q.push_back(6'b00_0000);
        push_run(8'b00_01_11_10, 0);
        push_run(8'b00_01_11_10, 0);
        repeat (66) next_cycle();
        start = 1'b0;
        wait_drain();

        // Random codes, some with a random abort point.
        for (int r = 0; r < 6; r++) begin
            logic [2*LEN-1:0] rc;
            int ab;
            rc = 8'($urandom);
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 32)) : 0;
            run_code(rc, ab);
        end

        // Async reset in the middle of a run: outputs clear at once and stay
        // clear after release until a new start.
        mon_en = 1'b0;
        next_cycle();
        code  = 8'b11_00_10_01;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (6) next_cycle();
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset", {done, busy, button}, 6'b00_0000);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("post_reset", {done, busy, button}, 6'b00_0000);
        end
        mon_en = 1'b1;
        run_code(8'b11_10_01_00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
